// File: rtl/spi_rx_frame_ctrl.sv
// rtl/spi_rx_frame_ctrl.sv - SPI mode-0 receive front end: pin sync, bit framing, frame status
// Optional watchdog on stalled SCLK inside a frame: define SPI_RX_TIMEOUT_EN.
module spi_rx_frame_ctrl #(
    parameter int WL          = 96,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic                    clk,
    input  logic                    iRST_N,
    input  logic                    iSCLK,
    input  logic                    iCS_N,
    input  logic                    iMOSI,
    output logic                    oSHIFT_IN,
    output logic                    oSHIFT_EN,
    output logic                    oFRAME_START,
    output logic                    oFRAME_VALID,
    output logic                    oFRAME_ERR,
    output logic                    oOVERRUN,
    output logic [$clog2(WL+1)-1:0] oBIT_CNT,
    output logic                    oBUSY
);

    localparam int CW = $clog2(WL + 1);
    localparam logic [CW-1:0] LP_LAST_BIT = CW'(WL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_post_rst;
    logic                   r_cs_armed;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_bit_cnt;
    logic                   r_shift_in;
    logic                   r_shift_en;
    logic                   r_frame_start;
    logic                   r_frame_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_shift_en;
    logic                   w_frame_valid;
    logic                   w_frame_err;
    logic                   w_ovr_set;
    logic                   w_timeout;

    always_ff @(posedge clk) begin
        if (!iRST_N) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_post_rst  <= 1'b0;
            r_cs_armed  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], iSCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], iCS_N};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], iMOSI};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
            r_post_rst  <= 1'b1;
            // A CS_N pin held low across reset must not look like a new frame start.
            r_cs_armed  <= r_cs_armed | (r_post_rst & r_cs_sync[0]);
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_cs_fall   = r_cs_armed & r_cs_d & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_d & w_cs_s;

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LP_TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_wdog;

    // r_wdog holds the clk cycles elapsed since the last SCLK edge (or frame start).
    always_ff @(posedge clk) begin
        if (!iRST_N) begin
            r_wdog <= '0;
        end else if (w_cs_fall || w_sclk_rise) begin
            r_wdog <= TW'(1);
        end else if (r_state == ST_RECV) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_timeout = (r_state == ST_RECV) && (r_wdog == LP_TMO_LAST) && !w_sclk_rise;
`else
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!iRST_N) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_shift_in    <= 1'b0;
            r_shift_en    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift_in    <= w_mosi_s;
            r_shift_en    <= w_shift_en;
            r_frame_start <= w_cs_fall;
            r_frame_valid <= w_frame_valid;
            r_frame_err   <= w_frame_err;
            if (w_cs_fall) begin
                r_overrun <= 1'b0;
            end else if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (w_cs_fall) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_fall) begin
            w_state_nxt = ST_RECV;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_RECV: begin
                    if (w_cs_rise || w_timeout) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_sclk_rise && (r_bit_cnt == LP_LAST_BIT)) begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_cs_rise) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // cs edges take priority over a coincident SCLK edge.
    always_comb begin
        w_shift_en    = (r_state == ST_RECV) && w_sclk_rise && !w_cs_rise && !w_cs_fall;
        w_ovr_set     = (r_state == ST_FULL) && w_sclk_rise && !w_cs_rise && !w_cs_fall;
        w_frame_err   = (r_state == ST_RECV) && !w_cs_fall && (w_cs_rise || w_timeout);
        w_frame_valid = (r_state == ST_FULL) && r_shift_en;
    end

    assign oSHIFT_IN    = r_shift_in;
    assign oSHIFT_EN    = r_shift_en;
    assign oFRAME_START = r_frame_start;
    assign oFRAME_VALID = r_frame_valid;
    assign oFRAME_ERR   = r_frame_err;
    assign oOVERRUN     = r_overrun;
    assign oBIT_CNT     = r_bit_cnt;
    assign oBUSY        = (r_state != ST_IDLE);

endmodule
